// File: rtl/spart_tx_arbiter.sv
// spart_tx_arbiter: round-robin share of the SPART TX FIFO, nibble-tagged word framing.
// Define SPART_TX_CHECK_EN to add an XOR check byte (tag 4'hE) before the terminator.
module spart_tx_arbiter #(
  parameter int         NREQ      = 2,
  parameter logic [3:0] SLOT_BASE = 4'h1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   wdata,
  output logic [NREQ-1:0]      gnt,
  output logic                 busy,
  input  logic                 fifo_full,
  output logic                 fifo_send,
  output logic [7:0]           fifo_data
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
`ifdef SPART_TX_CHECK_EN
    CHK,
`endif
    TERM,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [15:0]     word_q, word_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [IDW-1:0]  win;
  logic [15:0]     word_sel;
  logic [3:0]      nib;
  logic [3:0]      tag;

  // Rotate so the rr pointer sits at bit 0, then take the lowest set bit.
  function automatic logic [IDW-1:0] rr_pick(
    input logic [NREQ-1:0] r,
    input logic [IDW-1:0]  p
  );
    logic [NREQ-1:0] rot;
    int              c;
    rot = (r >> p) | (r << (NREQ - int'(p)));
    c   = int'(p);
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) c = int'(p) + k;
    end
    if (c >= NREQ) c = c - NREQ;
    return IDW'(c);
  endfunction

  always_comb begin
    win      = rr_pick(req, rr_q);
    word_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == win) word_sel = wdata[16*i +: 16];
    end
  end

  always_comb begin
    nib = 4'h0;
    unique case (idx_q)
      2'd0: nib = word_q[15:12];
      2'd1: nib = word_q[11:8];
      2'd2: nib = word_q[7:4];
      2'd3: nib = word_q[3:0];
      default: nib = 4'h0;
    endcase
  end

  assign tag  = SLOT_BASE + {2'b00, idx_q};
  assign busy = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    word_d    = word_q;
    id_d      = id_q;
    rr_d      = rr_q;
    fifo_send = 1'b0;
    fifo_data = 8'h00;
    gnt       = '0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          id_d    = win;
          word_d  = word_sel;
          idx_d   = 2'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        fifo_send = ~fifo_full;
        if (!fifo_full) begin
          fifo_data = {tag, nib};
          idx_d     = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
`ifdef SPART_TX_CHECK_EN
            state_d = CHK;
`else
            state_d = TERM;
`endif
          end
        end
      end
`ifdef SPART_TX_CHECK_EN
      CHK: begin
        fifo_send = ~fifo_full;
        if (!fifo_full) begin
          fifo_data = {4'hE, word_q[15:12] ^ word_q[11:8]
                             ^ word_q[7:4] ^ word_q[3:0]};
          state_d   = TERM;
        end
      end
`endif
      TERM: begin
        fifo_send = ~fifo_full;
        if (!fifo_full) begin
          fifo_data = {4'hF, 4'(id_q)};
          state_d   = DONE;
        end
      end
      DONE: begin
        gnt     = NREQ'(1) << id_q;
        rr_d    = (int'(id_q) == NREQ - 1) ? '0 : id_q + IDW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      word_q  <= '0;
      id_q    <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
    end
  end

endmodule

// File: tb/tb_spart_tx_arbiter.sv
// tb_spart_tx_arbiter: byte-stream reference model plus directed literal frames.
// Honours SPART_TX_CHECK_EN for frame length and the check byte.
module tb_spart_tx_arbiter;
  localparam int NREQ = 2;
  localparam logic [3:0] SB = 4'h1;
`ifdef SPART_TX_CHECK_EN
  localparam int NB = 6;
`else
  localparam int NB = 5;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [16*NREQ-1:0] wdata = '0;
  logic fifo_full = 1'b0;
  logic [NREQ-1:0] gnt;
  logic busy;
  logic fifo_send;
  logic [7:0] fifo_data;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  spart_tx_arbiter #(.NREQ(NREQ), .SLOT_BASE(SB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata),
    .gnt(gnt), .busy(busy), .fifo_full(fifo_full),
    .fifo_send(fifo_send), .fifo_data(fifo_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Model: a frame is a byte array; a position walks it, stalling on full.
  bit m_ok = 0;
  bit m_busy = 0;
  int m_pos = 0;
  int m_id = 0;
  int m_rr = 0;
  logic [7:0] m_frame[NB];

  function automatic void build(input logic [15:0] w);
    logic [3:0] x = 4'h0;
    for (int j = 0; j < 4; j++) begin
      m_frame[j] = {SB + 4'(j), w[15-4*j -: 4]};
      x ^= w[15-4*j -: 4];
    end
`ifdef SPART_TX_CHECK_EN
    m_frame[4] = {4'hE, x};
`endif
    m_frame[NB-1] = {4'hF, 4'(m_id)};
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_ok = 1; m_busy = 0; m_pos = 0; m_rr = 0;
    end else if (!m_busy) begin
      if (req != '0) begin
        m_id = -1;
        for (int k = 0; k < NREQ; k++)
          if (m_id < 0 && req[(m_rr + k) % NREQ]) m_id = (m_rr + k) % NREQ;
        build(wdata[16*m_id +: 16]);
        m_busy = 1; m_pos = 0;
      end
    end else if (m_pos < NB) begin
      if (!fifo_full) m_pos++;
    end else begin
      m_busy = 0;
      m_rr = (m_id + 1) % NREQ;
    end
  end

  logic [NREQ-1:0] gnt_seen = '0;
  logic [7:0] log_q[$];
  logic [7:0] exp_q[$];
  int gnt_cnt[NREQ];
  int others[NREQ];
  int gnt_cyc = 0;
  int first_cyc = -1;

  always @(negedge clk) begin
    logic e_send;
    logic [7:0] e_data;
    logic [NREQ-1:0] e_gnt;
    if (m_ok) begin
      e_send = m_busy && (m_pos < NB) && !fifo_full;
      e_data = 8'h00;
      if (e_send) e_data = m_frame[m_pos];
      e_gnt = '0;
      if (m_busy && m_pos == NB) e_gnt[m_id] = 1'b1;
      chk("busy", busy, m_busy);
      chk("fifo_send", fifo_send, e_send);
      chk("fifo_data", fifo_data, e_data);
      chk("gnt", gnt, e_gnt);
    end
    if (fifo_send === 1'b1) begin
      if (log_q.size() == 0) first_cyc = cyc;
      log_q.push_back(fifo_data);
    end
    gnt_seen = gnt;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i] === 1'b1) begin gnt_cnt[i]++; gnt_cyc = cyc; end
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) others[i] = 0;
    end else if ((|gnt) === 1'b1) begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i]) others[i] = 0;
        else if (req[i]) begin
          others[i]++;
          chk("starve", others[i] <= NREQ - 1, 1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) if (gnt_seen[i] === 1'b1) req[i] = 1'b0;
  endtask

  task automatic clr();
    log_q.delete(); exp_q.delete(); first_cyc = -1;
  endtask

  function automatic void add_frame(input logic [7:0] b0, b1, b2, b3,
                                    input logic [7:0] ck, term);
    exp_q.push_back(b0); exp_q.push_back(b1);
    exp_q.push_back(b2); exp_q.push_back(b3);
`ifdef SPART_TX_CHECK_EN
    exp_q.push_back(ck);
`endif
    exp_q.push_back(term);
  endfunction

  task automatic chk_log(input string nm);
    chk({nm, "_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk(nm, log_q[i], exp_q[i]);
  endtask

  task automatic wait_log(input int n, input int lim);
    int t = 0;
    while (log_q.size() < n && t < lim) begin tick(); t++; end
    chk("wait_log", log_q.size() >= n, 1);
  endtask

  initial begin
    int g1;
    int t;
    // reset state
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_send", fifo_send, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_data", fifo_data, 0);

    // 1: single word
    clr();
    rst_n = 1; req = 2'b01; wdata[15:0] = 16'hA5C3;
    for (int i = 0; i < 10; i++) tick();
    add_frame(8'h1A, 8'h25, 8'h3C, 8'h43, 8'hE0, 8'hF0);
    chk_log("t1");
    chk("t1_gnt", gnt_cnt[0], 1);
    chk("t1_lat", gnt_cyc - first_cyc, NB);

    // 2: both requesting from reset, then req0 returns
    rst_n = 0; req = 2'b11; wdata = {16'hBEEF, 16'h1234};
    tick(); rst_n = 1; clr();
    g1 = gnt_cnt[1]; t = 0;
    while (gnt_cnt[1] == g1 && t < 40) begin tick(); t++; end
    chk("t2_wait", gnt_cnt[1], g1 + 1);
    req[0] = 1'b1; wdata[15:0] = 16'h1234;
    for (int i = 0; i < 10; i++) tick();
    add_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'hE4, 8'hF0);
    add_frame(8'h1B, 8'h2E, 8'h3E, 8'h4F, 8'hE4, 8'hF1);
    add_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'hE4, 8'hF0);
    chk_log("t2");

    // 3: backpressure on the 2nd nibble
    clr(); req[0] = 1'b1; wdata[15:0] = 16'h1234;
    wait_log(1, 20);
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t3_hold", fifo_send, 0);
      tick();
    end
    fifo_full = 1'b0;
    #1 chk("t3_resume", {fifo_send, fifo_data[7:4]}, {1'b1, 4'h2});
    for (int i = 0; i < 10; i++) tick();
    add_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'hE4, 8'hF0);
    chk_log("t3");

    // 4: reset mid-frame; byte on the reset edge is still accepted
    clr(); req[0] = 1'b1; wdata[15:0] = 16'h1234;
    wait_log(2, 20);
    rst_n = 0; tick(); rst_n = 1;
    chk("t4_busy", busy, 0);
    chk("t4_send", fifo_send, 0);
    chk("t4_gnt", gnt, 0);
    for (int i = 0; i < 10; i++) tick();
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    add_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'hE4, 8'hF0);
    chk_log("t4");

`ifdef SPART_TX_CHECK_EN
    chk("t5_ck", log_q[7], 8'hE4);
`endif

    // 6: random traffic, backpressure, mid-frame req/wdata churn
    for (int n = 0; n < 4000; n++) begin
      tick();
      rst_n = ($urandom_range(0, 599) != 0);
      fifo_full = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (m_busy && m_id == i) begin
          wdata[16*i +: 16] = 16'($urandom);
          if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
        end else if (!req[i] && gnt_seen[i] !== 1'b1) begin
          wdata[16*i +: 16] = 16'($urandom);
          if ($urandom_range(0, 3) == 0) req[i] = 1'b1;
        end
      end
    end
    rst_n = 1; fifo_full = 0;
    for (int i = 0; i < 40; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
